// File: rtl/prim_fifo_sync.sv
// rtl/prim_fifo_sync.sv - single-clock ready/valid FIFO with optional pass-through
//
// Purpose: same-domain FIFO for response queues and request buffering.
// Optional build macro: PRIM_FIFO_SYNC_CLR_EN adds the clr_i synchronous flush input.
//
// Ports:
//   clk_i   in   1       clock, all state updates on the rising edge
//   rst_ni  in   1       asynchronous active-low reset
//   clr_i   in   1       synchronous flush (only with PRIM_FIFO_SYNC_CLR_EN)
//   wvalid  in   1       write request
//   wready  out  1       FIFO can accept a write (!full)
//   wdata   in   Width   write data
//   rvalid  out  1       read data available
//   rready  in   1       consumer accepts rdata
//   rdata   out  Width   head entry (or wdata when passing through)
//   depth   out  DepthW  number of stored entries
module prim_fifo_sync #(
  parameter int   Width  = 16,
  parameter logic Pass   = 1'b1,
  parameter int   Depth  = 4,
  localparam int  DepthW = $clog2(Depth + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
`ifdef PRIM_FIFO_SYNC_CLR_EN
  input  logic              clr_i,
`endif
  input  logic              wvalid,
  output logic              wready,
  input  logic [Width-1:0]  wdata,
  output logic              rvalid,
  input  logic              rready,
  output logic [Width-1:0]  rdata,
  output logic [DepthW-1:0] depth
);

  // Low bits index storage, the extra MSB is a wrap flag distinguishing full from empty.
  localparam int PtrvW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int PtrW  = PtrvW + 1;

  logic [PtrW-1:0]  wptr, rptr;
  logic [Width-1:0] mem [Depth];

  logic [PtrvW-1:0] wlow, rlow;
  logic             wmsb, rmsb;
  logic             empty, full;
  logic             pass_thru;
  logic             flush;
  logic             wr_en, rd_en;

  // Wrap at Depth-1 rather than at a power of two so non-power-of-2 depths work.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    logic [PtrW-1:0] n;
    if (p[PtrvW-1:0] == PtrvW'(Depth - 1)) begin
      n = {~p[PtrW-1], {PtrvW{1'b0}}};
    end else begin
      n = p + PtrW'(1);
    end
    return n;
  endfunction

  assign wlow = wptr[PtrvW-1:0];
  assign rlow = rptr[PtrvW-1:0];
  assign wmsb = wptr[PtrW-1];
  assign rmsb = rptr[PtrW-1];

  assign empty = (wptr == rptr);
  assign full  = (wlow == rlow) && (wmsb != rmsb);

`ifdef PRIM_FIFO_SYNC_CLR_EN
  assign flush = clr_i;
`else
  assign flush = 1'b0;
`endif

  // Empty FIFO with a consumer ready: data bypasses storage entirely.
  assign pass_thru = Pass && empty && wvalid && rready;

  // wready depends only on state, so a full FIFO refuses a write even if a read
  // frees a slot in the same cycle.
  assign wready = !full;
  assign wr_en  = wvalid && !full && !pass_thru && !flush;
  assign rd_en  = rready && !empty && !flush;

  assign rvalid = !empty || (Pass && wvalid);
  assign rdata  = (Pass && empty) ? wdata : mem[rlow];

  always_comb begin
    depth = '0;
    if (full) begin
      depth = DepthW'(Depth);
    end else if (wmsb == rmsb) begin
      depth = DepthW'(wlow) - DepthW'(rlow);
    end else begin
      depth = DepthW'(Depth) - DepthW'(rlow) + DepthW'(wlow);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_en) wptr <= ptr_inc(wptr);
      if (rd_en) rptr <= ptr_inc(rptr);
    end
  end

  // Storage is deliberately not reset; the pointers alone define validity.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wlow] <= wdata;
  end

endmodule

// File: tb/tb_prim_fifo_sync.sv
// tb/tb_prim_fifo_sync.sv - directed bench for prim_fifo_sync, Pass=1 and Pass=0 at Depth=3
module tb_prim_fifo_sync;

  localparam int W = 16;
  localparam int D = 3;

  logic         clk;
  logic         rst_n;
  logic         wv, rr;
  logic [W-1:0] wd;
`ifdef PRIM_FIFO_SYNC_CLR_EN
  logic         clr;
`endif

  logic         p_wready, p_rvalid, n_wready, n_rvalid;
  logic [W-1:0] p_rdata, n_rdata;
  logic [1:0]   p_depth, n_depth;

  int checks   = 0;
  int failures = 0;

  prim_fifo_sync #(.Width(W), .Pass(1'b1), .Depth(D)) u_pass (
    .clk_i  (clk),
    .rst_ni (rst_n),
`ifdef PRIM_FIFO_SYNC_CLR_EN
    .clr_i  (clr),
`endif
    .wvalid (wv),
    .wready (p_wready),
    .wdata  (wd),
    .rvalid (p_rvalid),
    .rready (rr),
    .rdata  (p_rdata),
    .depth  (p_depth)
  );

  prim_fifo_sync #(.Width(W), .Pass(1'b0), .Depth(D)) u_nopass (
    .clk_i  (clk),
    .rst_ni (rst_n),
`ifdef PRIM_FIFO_SYNC_CLR_EN
    .clr_i  (clr),
`endif
    .wvalid (wv),
    .wready (n_wready),
    .wdata  (wd),
    .rvalid (n_rvalid),
    .rready (rr),
    .rdata  (n_rdata),
    .depth  (n_depth)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic         wv;
    logic         rr;
    logic [W-1:0] wd;
    logic         p_rv;
    logic [W-1:0] p_rd;
    logic [1:0]   p_dp;
    logic         p_wr;
    logic         n_rv;
    logic [W-1:0] n_rd;
    logic [1:0]   n_dp;
    logic         n_wr;
  } vec_t;

  vec_t vec [13];

  logic [W-1:0] qp [$];
  logic [W-1:0] qn [$];

  task automatic check_model(input string tag, input logic pass, input logic [W-1:0] q [$],
                             input logic rv, input logic [W-1:0] rd,
                             input logic [1:0] dp, input logic wr);
    logic exp_rv;
    exp_rv = (q.size() > 0) || (pass && wv);
    check({tag, "_rvalid"}, {31'b0, rv}, {31'b0, exp_rv});
    if (exp_rv) check({tag, "_rdata"}, {16'b0, rd}, {16'b0, (q.size() > 0) ? q[0] : wd});
    check({tag, "_depth"}, {30'b0, dp}, q.size());
    check({tag, "_wready"}, {31'b0, wr}, {31'b0, q.size() < D});
  endtask

  task automatic model_edge(input logic pass, inout logic [W-1:0] q [$]);
    int sz;
    sz = q.size();
    if (!(pass && sz == 0 && wv && rr)) begin
      if (rr && sz > 0) void'(q.pop_front());
      if (wv && sz < D) q.push_back(wd);
    end
  endtask

  initial begin
    // {wv, rr, wd, pass: rvalid rdata depth wready, nopass: rvalid rdata depth wready}
    vec[0]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 2'd0, 1'b1, 1'b0, 16'h0000, 2'd0, 1'b1};
    vec[1]  = '{1'b1, 1'b0, 16'hA001, 1'b1, 16'hA001, 2'd0, 1'b1, 1'b0, 16'h0000, 2'd0, 1'b1};
    vec[2]  = '{1'b1, 1'b0, 16'hA002, 1'b1, 16'hA001, 2'd1, 1'b1, 1'b1, 16'hA001, 2'd1, 1'b1};
    vec[3]  = '{1'b1, 1'b0, 16'hA003, 1'b1, 16'hA001, 2'd2, 1'b1, 1'b1, 16'hA001, 2'd2, 1'b1};
    vec[4]  = '{1'b1, 1'b0, 16'hA004, 1'b1, 16'hA001, 2'd3, 1'b0, 1'b1, 16'hA001, 2'd3, 1'b0};
    vec[5]  = '{1'b1, 1'b1, 16'hA005, 1'b1, 16'hA001, 2'd3, 1'b0, 1'b1, 16'hA001, 2'd3, 1'b0};
    vec[6]  = '{1'b0, 1'b1, 16'h0000, 1'b1, 16'hA002, 2'd2, 1'b1, 1'b1, 16'hA002, 2'd2, 1'b1};
    vec[7]  = '{1'b0, 1'b1, 16'h0000, 1'b1, 16'hA003, 2'd1, 1'b1, 1'b1, 16'hA003, 2'd1, 1'b1};
    vec[8]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 2'd0, 1'b1, 1'b0, 16'h0000, 2'd0, 1'b1};
    vec[9]  = '{1'b1, 1'b1, 16'h5A5A, 1'b1, 16'h5A5A, 2'd0, 1'b1, 1'b0, 16'h0000, 2'd0, 1'b1};
    vec[10] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 2'd0, 1'b1, 1'b1, 16'h5A5A, 2'd1, 1'b1};
    vec[11] = '{1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000, 2'd0, 1'b1, 1'b1, 16'h5A5A, 2'd1, 1'b1};
    vec[12] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 2'd0, 1'b1, 1'b0, 16'h0000, 2'd0, 1'b1};

    rst_n = 1'b0;
    wv = 1'b0;
    rr = 1'b0;
    wd = '0;
`ifdef PRIM_FIFO_SYNC_CLR_EN
    clr = 1'b0;
`endif
    step();
    step();
    rst_n = 1'b1;

    // Fill, overflow attempt, full read+write, drain, pass-through vs one-cycle latency.
    for (int i = 0; i < 13; i++) begin
      wv = vec[i].wv;
      rr = vec[i].rr;
      wd = vec[i].wd;
      @(negedge clk);
      check($sformatf("v%0d_p_rvalid", i), {31'b0, p_rvalid}, {31'b0, vec[i].p_rv});
      if (vec[i].p_rv) check($sformatf("v%0d_p_rdata", i), {16'b0, p_rdata}, {16'b0, vec[i].p_rd});
      check($sformatf("v%0d_p_depth", i), {30'b0, p_depth}, {30'b0, vec[i].p_dp});
      check($sformatf("v%0d_p_wready", i), {31'b0, p_wready}, {31'b0, vec[i].p_wr});
      check($sformatf("v%0d_n_rvalid", i), {31'b0, n_rvalid}, {31'b0, vec[i].n_rv});
      if (vec[i].n_rv) check($sformatf("v%0d_n_rdata", i), {16'b0, n_rdata}, {16'b0, vec[i].n_rd});
      check($sformatf("v%0d_n_depth", i), {30'b0, n_depth}, {30'b0, vec[i].n_dp});
      check($sformatf("v%0d_n_wready", i), {31'b0, n_wready}, {31'b0, vec[i].n_wr});
      step();
    end

    // Streaming with irregular valid/ready so pointers wrap several times at varying depth.
    for (int i = 0; i < 24; i++) begin
      wv = (i % 5) != 4;
      rr = (i % 3) != 0;
      wd = 16'hC000 + 16'(i);
      @(negedge clk);
      check_model($sformatf("s%0d_p", i), 1'b1, qp, p_rvalid, p_rdata, p_depth, p_wready);
      check_model($sformatf("s%0d_n", i), 1'b0, qn, n_rvalid, n_rdata, n_depth, n_wready);
      model_edge(1'b1, qp);
      model_edge(1'b0, qn);
      step();
    end

    // Drain, then load two entries and pulse reset between edges.
    wv = 1'b0;
    rr = 1'b1;
    for (int i = 0; i < 4; i++) step();
    rr = 1'b0;
    wv = 1'b1;
    wd = 16'hB001;
    step();
    wd = 16'hB002;
    step();
    wv = 1'b0;
    @(negedge clk);
    check("pre_rst_n_depth", {30'b0, n_depth}, 32'd2);
    check("pre_rst_p_depth", {30'b0, p_depth}, 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_n_rvalid", {31'b0, n_rvalid}, 32'd0);
    check("rst_p_rvalid", {31'b0, p_rvalid}, 32'd0);
    check("rst_n_depth", {30'b0, n_depth}, 32'd0);
    check("rst_p_depth", {30'b0, p_depth}, 32'd0);
    check("rst_n_wready", {31'b0, n_wready}, 32'd1);
    check("rst_p_wready", {31'b0, p_wready}, 32'd1);
    step();
    rst_n = 1'b1;
    step();
    check("post_rst_n_depth", {30'b0, n_depth}, 32'd0);

`ifdef PRIM_FIFO_SYNC_CLR_EN
    // Flush at depth 2 with a concurrent write: the written word must never surface.
    wv = 1'b1;
    wd = 16'hB011;
    step();
    wd = 16'hB012;
    step();
    wd = 16'hDEAD;
    clr = 1'b1;
    @(negedge clk);
    check("clr_hold_depth", {30'b0, n_depth}, 32'd2);
    check("clr_hold_rvalid", {31'b0, n_rvalid}, 32'd1);
    step();
    clr = 1'b0;
    wv = 1'b0;
    @(negedge clk);
    check("clr_n_depth", {30'b0, n_depth}, 32'd0);
    check("clr_p_depth", {30'b0, p_depth}, 32'd0);
    check("clr_n_rvalid", {31'b0, n_rvalid}, 32'd0);
    step();
    wv = 1'b1;
    wd = 16'hBEEF;
    step();
    wv = 1'b0;
    @(negedge clk);
    check("clr_after_depth", {30'b0, n_depth}, 32'd1);
    check("clr_after_rdata", {16'b0, n_rdata}, 32'h0000BEEF);
    check("clr_after_p_rdata", {16'b0, p_rdata}, 32'h0000BEEF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
